// File: rtl/bconv_seq.sv
// Frame sequencer for a weight-stationary binary conv engine: per row, each
// output-channel group loads its weights, commits them, then streams the row.
module bconv_seq #(
  parameter int CHANNEL = 256,
  parameter int SIZE    = 56,
  parameter int BATCH   = 2,
  parameter int PACK    = 8,
  parameter int WIDTH_W = 18,
  parameter int GAP     = 0,
  parameter int PB      = CHANNEL / PACK,
  parameter int GROUPS  = CHANNEL / BATCH,
  parameter int WA      = $clog2(GROUPS * PB),
  parameter int PA      = $clog2(SIZE)
) (
  input  logic                      i_sclk,
  input  logic                      i_rst,
  input  logic                      i_start,
  input  logic                      i_abort,
  input  logic                      i_ready,
  output logic                      o_wt_rd_en,
  output logic [WA-1:0]             o_wt_rd_addr,
  input  logic [WIDTH_W*PACK-1:0]   i_wt_rd_data,
  output logic                      o_weight_vld,
  output logic [WIDTH_W*PACK-1:0]   o_weight,
  output logic                      o_fm_rd_en,
  output logic [PA-1:0]             o_fm_col,
  output logic [PA-1:0]             o_fm_row,
  output logic                      o_vsync,
  output logic                      o_hsync,
  output logic                      o_reuse,
  output logic                      o_valid,
  output logic                      o_busy,
  output logic                      o_done
);

  localparam int BW  = (PB > 1) ? $clog2(PB) : 1;
  localparam int GW  = (GROUPS > 1) ? $clog2(GROUPS) : 1;
  localparam int GPW = (GAP > 1) ? $clog2(GAP) : 1;

  // IDLE wait start | VS frame sync | HS row sync | WCHK wait ready | WLOAD weight beats
  // WLAT last beat lands | REUSE commit | STREAM row pixels | GAP idle | DONE frame end
  typedef enum logic [3:0] {
    S_IDLE, S_VS, S_HS, S_WCHK, S_WLOAD, S_WLAT, S_REUSE, S_STREAM, S_GAP, S_DONE
  } state_t;

  state_t                    r_state;
  logic [PA-1:0]             r_row;
  logic [PA-1:0]             r_col;
  logic [GW-1:0]             r_group;
  logic [BW-1:0]             r_beat;
  logic [GPW-1:0]            r_gcnt;
  logic [WA-1:0]             r_gaddr;
  logic [WA-1:0]             r_addr;
  logic                      r_rd_en;
  logic                      r_fm_en;
  logic                      r_vsync;
  logic                      r_hsync;
  logic                      r_reuse;
  logic                      r_done;
  logic                      r_busy;
  logic                      r_wvld;
  logic [WIDTH_W*PACK-1:0]   r_weight;
  logic                      r_valid;

  logic [WA-1:0]             w_gaddr_next;
  logic                      w_grp_end;
  logic                      w_last_group;
  logic                      w_last_row;

  // Base address walks in PB steps so the read address never needs a multiplier.
  assign w_gaddr_next = r_gaddr + WA'(PB);
  assign w_last_group = (r_group == GW'(GROUPS - 1));
  assign w_last_row   = (r_row == PA'(SIZE - 1));
  assign w_grp_end    = ((r_state == S_STREAM) && (r_col == PA'(SIZE - 1)) && (GAP == 0)) ||
                        ((r_state == S_GAP) && (r_gcnt == GPW'(GAP - 1)));

  always_ff @(posedge i_sclk or posedge i_rst) begin
    if (i_rst) begin
      r_state  <= S_IDLE;
      r_row    <= '0;
      r_col    <= '0;
      r_group  <= '0;
      r_beat   <= '0;
      r_gcnt   <= '0;
      r_gaddr  <= '0;
      r_addr   <= '0;
      r_rd_en  <= 1'b0;
      r_fm_en  <= 1'b0;
      r_vsync  <= 1'b0;
      r_hsync  <= 1'b0;
      r_reuse  <= 1'b0;
      r_done   <= 1'b0;
      r_busy   <= 1'b0;
      r_wvld   <= 1'b0;
      r_weight <= '0;
      r_valid  <= 1'b0;
    end else begin
      // Delay stages run independently of the FSM so an abort still finishes in-flight beats.
      r_wvld   <= r_rd_en;
      r_weight <= i_wt_rd_data;
      r_valid  <= r_fm_en;
      r_vsync  <= 1'b0;
      r_hsync  <= 1'b0;
      r_reuse  <= 1'b0;
      r_done   <= 1'b0;
      r_rd_en  <= 1'b0;
      r_fm_en  <= 1'b0;
      if ((r_state != S_IDLE) && i_abort) begin
        r_state <= S_IDLE;
        r_busy  <= 1'b0;
      end else if (w_grp_end) begin
        if (!w_last_group) begin
          r_group <= r_group + 1'b1;
          r_gaddr <= w_gaddr_next;
          if (i_ready) begin
            r_state <= S_WLOAD;
            r_rd_en <= 1'b1;
            r_addr  <= w_gaddr_next;
            r_beat  <= '0;
          end else begin
            r_state <= S_WCHK;
          end
        end else if (!w_last_row) begin
          r_row   <= r_row + 1'b1;
          r_group <= '0;
          r_gaddr <= '0;
          r_state <= S_HS;
          r_hsync <= 1'b1;
        end else begin
          r_state <= S_DONE;
          r_done  <= 1'b1;
        end
      end else begin
        case (r_state)
          S_IDLE: begin
            if (i_start && !i_abort) begin
              r_state <= S_VS;
              r_vsync <= 1'b1;
              r_busy  <= 1'b1;
              r_row   <= '0;
              r_col   <= '0;
              r_group <= '0;
              r_beat  <= '0;
              r_gcnt  <= '0;
              r_gaddr <= '0;
            end
          end
          S_VS: begin
            r_state <= S_HS;
            r_hsync <= 1'b1;
          end
          S_HS, S_WCHK: begin
            if (i_ready) begin
              r_state <= S_WLOAD;
              r_rd_en <= 1'b1;
              r_addr  <= r_gaddr;
              r_beat  <= '0;
            end else begin
              r_state <= S_WCHK;
            end
          end
          S_WLOAD: begin
            if (r_beat == BW'(PB - 1)) begin
              r_state <= S_WLAT;
            end else begin
              r_beat  <= r_beat + 1'b1;
              r_addr  <= r_addr + 1'b1;
              r_rd_en <= 1'b1;
            end
          end
          S_WLAT: begin
            r_state <= S_REUSE;
            r_reuse <= 1'b1;
          end
          S_REUSE: begin
            r_state <= S_STREAM;
            r_fm_en <= 1'b1;
            r_col   <= '0;
          end
          S_STREAM: begin
            if (r_col != PA'(SIZE - 1)) begin
              r_col   <= r_col + 1'b1;
              r_fm_en <= 1'b1;
            end else begin
              r_state <= S_GAP;
              r_gcnt  <= '0;
            end
          end
          S_GAP: begin
            r_gcnt <= r_gcnt + 1'b1;
          end
          S_DONE: begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
          default: begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign o_wt_rd_en   = r_rd_en;
  assign o_wt_rd_addr = r_addr;
  assign o_weight_vld = r_wvld;
  assign o_weight     = r_weight;
  assign o_fm_rd_en   = r_fm_en;
  assign o_fm_col     = r_col;
  assign o_fm_row     = r_row;
  assign o_vsync      = r_vsync;
  assign o_hsync      = r_hsync;
  assign o_reuse      = r_reuse;
  assign o_valid      = r_valid;
  assign o_busy       = r_busy;
  assign o_done       = r_done;

endmodule

// File: tb/tb_bconv_seq.sv
// Bench for bconv_seq: GAP=2 and GAP=0 instances share stimulus; a timeline
// model plus a checkpoint table and hand sequences for abort/reset.
module tb_bconv_seq;
  localparam int SZ  = 4;
  localparam int PBV = 2;
  localparam int NG  = 8;
  localparam int NC  = 700;
  localparam int W   = 144;
  localparam int NT  = 20;

  typedef struct packed {
    logic       vsync, hsync, rd_en;
    logic [3:0] addr;
    logic       wvld, reuse, fm_en;
    logic [1:0] col, row;
    logic       valid, done, busy;
  } obs_t;

  typedef struct {
    int   cyc;
    obs_t o;
  } vec_t;

  logic clk_sys = 1'b0;
  logic i_rst, i_start, i_abort, i_ready;
  logic [W-1:0] i_wt_rd_data;
  logic [W-1:0] wd_cur, wd_prev;

  logic a_rd_en, a_wvld, a_fm_en, a_vsync, a_hsync, a_reuse, a_valid, a_busy, a_done;
  logic [3:0] a_addr;
  logic [1:0] a_col, a_row;
  logic [W-1:0] a_weight;
  logic b_rd_en, b_wvld, b_fm_en, b_vsync, b_hsync, b_reuse, b_valid, b_busy, b_done;
  logic [3:0] b_addr;
  logic [1:0] b_col, b_row;
  logic [W-1:0] b_weight;

  int   n_tests = 0;
  int   n_fail  = 0;
  obs_t ex[2][NC];
  bit   rdy[NC];
  int   exp_done[2];
  vec_t tbl[NT];

  always #5 clk_sys = ~clk_sys;

  bconv_seq #(.CHANNEL(16), .SIZE(SZ), .BATCH(2), .PACK(8), .WIDTH_W(18), .GAP(2)) dut_a (
    .i_sclk(clk_sys), .i_rst(i_rst), .i_start(i_start), .i_abort(i_abort), .i_ready(i_ready),
    .o_wt_rd_en(a_rd_en), .o_wt_rd_addr(a_addr), .i_wt_rd_data(i_wt_rd_data),
    .o_weight_vld(a_wvld), .o_weight(a_weight), .o_fm_rd_en(a_fm_en), .o_fm_col(a_col),
    .o_fm_row(a_row), .o_vsync(a_vsync), .o_hsync(a_hsync), .o_reuse(a_reuse),
    .o_valid(a_valid), .o_busy(a_busy), .o_done(a_done));

  bconv_seq #(.CHANNEL(16), .SIZE(SZ), .BATCH(2), .PACK(8), .WIDTH_W(18), .GAP(0)) dut_b (
    .i_sclk(clk_sys), .i_rst(i_rst), .i_start(i_start), .i_abort(i_abort), .i_ready(i_ready),
    .o_wt_rd_en(b_rd_en), .o_wt_rd_addr(b_addr), .i_wt_rd_data(i_wt_rd_data),
    .o_weight_vld(b_wvld), .o_weight(b_weight), .o_fm_rd_en(b_fm_en), .o_fm_col(b_col),
    .o_fm_row(b_row), .o_vsync(b_vsync), .o_hsync(b_hsync), .o_reuse(b_reuse),
    .o_valid(b_valid), .o_busy(b_busy), .o_done(b_done));

  function automatic obs_t rd_a();
    return '{a_vsync, a_hsync, a_rd_en, a_addr, a_wvld, a_reuse, a_fm_en, a_col, a_row,
             a_valid, a_done, a_busy};
  endfunction

  function automatic obs_t rd_b();
    return '{b_vsync, b_hsync, b_rd_en, b_addr, b_wvld, b_reuse, b_fm_en, b_col, b_row,
             b_valid, b_done, b_busy};
  endfunction

  // address/column/row only carry meaning while their strobe is up
  function automatic obs_t norm(input obs_t x);
    obs_t y;
    y = x;
    if (!y.rd_en) y.addr = '0;
    if (!y.fm_en) begin
      y.col = '0;
      y.row = '0;
    end
    return y;
  endfunction

  function automatic obs_t mk(input bit v, h, r, input int ad, input bit w, re, f,
                              input int c, ro, input bit va, d, b);
    obs_t o;
    o.vsync = v; o.hsync = h; o.rd_en = r; o.addr = 4'(ad); o.wvld = w; o.reuse = re;
    o.fm_en = f; o.col = 2'(c); o.row = 2'(ro); o.valid = va; o.done = d; o.busy = b;
    return o;
  endfunction

  task automatic chk(input bit ok, input string name, input int k,
                     input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%h want=%h", name, k, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_sys);
    #1;
  endtask

  // Timeline model: each group occupies stall + PB + 2 + SIZE + gap cycles.
  task automatic build(input int d, input int gap);
    int c;
    for (int k = 0; k < NC; k++) ex[d][k] = '0;
    ex[d][1].vsync = 1'b1;
    c = 2;
    for (int r = 0; r < SZ; r++) begin
      ex[d][c].hsync = 1'b1;
      c++;
      for (int g = 0; g < NG; g++) begin
        while (!rdy[c-1] && c < NC - 40) c++;
        for (int b = 0; b < PBV; b++) begin
          ex[d][c].rd_en = 1'b1;
          ex[d][c].addr = 4'(g * PBV + b);
          ex[d][c+1].wvld = 1'b1;
          c++;
        end
        c++;
        ex[d][c].reuse = 1'b1;
        c++;
        for (int x = 0; x < SZ; x++) begin
          ex[d][c].fm_en = 1'b1;
          ex[d][c].col = 2'(x);
          ex[d][c].row = 2'(r);
          ex[d][c+1].valid = 1'b1;
          c++;
        end
        c += gap;
      end
    end
    ex[d][c].done = 1'b1;
    exp_done[d] = c;
    for (int k = 1; k <= c; k++) ex[d][k].busy = 1'b1;
  endtask

  // mode 0: ready held high, 1: 5-cycle stall before group 2, 2: random ready and stray starts
  task automatic run_frame(input int mode);
    int   last, lim;
    int   seen[2];
    obs_t act;
    for (int k = 0; k < NC; k++)
      rdy[k] = (mode == 2) ? ($urandom_range(0, 3) != 0) : !(mode == 1 && k >= 22 && k <= 26);
    build(0, 2);
    build(1, 0);
    last = ((exp_done[0] > exp_done[1]) ? exp_done[0] : exp_done[1]) + 2;
    lim  = (exp_done[0] < exp_done[1]) ? exp_done[0] : exp_done[1];
    seen[0] = -1;
    seen[1] = -1;
    for (int k = 0; k <= last && k < NC; k++) begin
      i_ready = rdy[k];
      i_start = (k == 0) || (mode == 2 && k < lim && $urandom_range(0, 7) == 0);
      @(negedge clk_sys);
      for (int d = 0; d < 2; d++) begin
        act = (d == 0) ? rd_a() : rd_b();
        if (act.done && seen[d] < 0) seen[d] = k;
        chk(norm(act) == norm(ex[d][k]), (d == 0) ? "trace_gap2" : "trace_gap0", k,
            32'(norm(act)), 32'(norm(ex[d][k])));
      end
      chk(a_weight == wd_prev && b_weight == wd_prev, "weight_delay", k,
          a_weight[31:0], wd_prev[31:0]);
      if (mode == 0)
        for (int i = 0; i < NT; i++)
          if (tbl[i].cyc == k)
            chk(norm(rd_a()) == norm(tbl[i].o), "table", k, 32'(norm(rd_a())), 32'(norm(tbl[i].o)));
      step();
    end
    i_start = 1'b0;
    i_ready = 1'b1;
    if (mode == 0) begin
      chk(seen[0] == 326, "done_cycle_gap2", 0, seen[0], 326);
      chk(seen[1] == 262, "done_cycle_gap0", 0, seen[1], 262);
    end
    if (mode == 1) chk(seen[0] == 331, "done_cycle_stall", 0, seen[0], 331);
  endtask

  function automatic bit all_zero();
    return rd_a() == '0 && rd_b() == '0 && a_weight == '0 && b_weight == '0;
  endfunction

  initial begin
    logic [159:0] r;
    wd_cur = '0;
    wd_prev = '0;
    i_wt_rd_data = '0;
    forever begin
      @(posedge clk_sys);
      #1;
      wd_prev = wd_cur;
      r = {$urandom, $urandom, $urandom, $urandom, $urandom};
      wd_cur = r[W-1:0];
      i_wt_rd_data = wd_cur;
    end
  end

  initial begin
    int n;
    tbl[0]  = '{0,   mk(0,0,0,0,0,0,0,0,0,0,0,0)};
    tbl[1]  = '{1,   mk(1,0,0,0,0,0,0,0,0,0,0,1)};
    tbl[2]  = '{2,   mk(0,1,0,0,0,0,0,0,0,0,0,1)};
    tbl[3]  = '{3,   mk(0,0,1,0,0,0,0,0,0,0,0,1)};
    tbl[4]  = '{4,   mk(0,0,1,1,1,0,0,0,0,0,0,1)};
    tbl[5]  = '{5,   mk(0,0,0,0,1,0,0,0,0,0,0,1)};
    tbl[6]  = '{6,   mk(0,0,0,0,0,1,0,0,0,0,0,1)};
    tbl[7]  = '{7,   mk(0,0,0,0,0,0,1,0,0,0,0,1)};
    tbl[8]  = '{10,  mk(0,0,0,0,0,0,1,3,0,1,0,1)};
    tbl[9]  = '{11,  mk(0,0,0,0,0,0,0,0,0,1,0,1)};
    tbl[10] = '{13,  mk(0,0,1,2,0,0,0,0,0,0,0,1)};
    tbl[11] = '{114, mk(0,0,1,6,0,0,0,0,0,0,0,1)};
    tbl[12] = '{115, mk(0,0,1,7,1,0,0,0,0,0,0,1)};
    tbl[13] = '{116, mk(0,0,0,0,1,0,0,0,0,0,0,1)};
    tbl[14] = '{117, mk(0,0,0,0,0,1,0,0,0,0,0,1)};
    tbl[15] = '{118, mk(0,0,0,0,0,0,1,0,1,0,0,1)};
    tbl[16] = '{121, mk(0,0,0,0,0,0,1,3,1,1,0,1)};
    tbl[17] = '{122, mk(0,0,0,0,0,0,0,0,0,1,0,1)};
    tbl[18] = '{326, mk(0,0,0,0,0,0,0,0,0,0,1,1)};
    tbl[19] = '{327, mk(0,0,0,0,0,0,0,0,0,0,0,0)};

    i_rst = 1'b1; i_start = 1'b0; i_abort = 1'b0; i_ready = 1'b1;
    repeat (3) @(posedge clk_sys);
    #2;
    chk(all_zero(), "reset_state", 0, 32'(rd_a()), 0);
    @(negedge clk_sys);
    i_rst = 1'b0;
    step();

    run_frame(0);
    run_frame(1);
    run_frame(2);
    run_frame(2);

    // abort mid-stream: one trailing valid, no done, clean restart
    i_start = 1'b1; step(); i_start = 1'b0;
    repeat (7) step();
    i_abort = 1'b1; step(); i_abort = 1'b0;
    @(negedge clk_sys);
    chk(!a_busy && !a_fm_en && a_valid && !b_busy && !b_fm_en && b_valid, "abort_stream", 9,
        {a_busy, a_fm_en, a_valid, b_busy, b_fm_en, b_valid}, 32'b001001);
    step(); @(negedge clk_sys);
    chk(!a_valid && !b_valid, "abort_trail_end", 10, {a_valid, b_valid}, 0);
    n = 0;
    repeat (20) begin
      step(); @(negedge clk_sys);
      if (a_done || b_done || a_busy || b_busy) n++;
    end
    chk(n == 0, "abort_quiet", 0, n, 0);
    step();
    i_start = 1'b1; step(); i_start = 1'b0;
    step(); @(negedge clk_sys);
    chk(a_hsync && b_hsync, "restart_hsync", 2, {a_hsync, b_hsync}, 3);
    step(); @(negedge clk_sys);
    chk(a_rd_en && a_addr == 0 && b_rd_en && b_addr == 0, "restart_addr0", 3, a_addr, 0);
    repeat (4) step();
    @(negedge clk_sys);
    chk(a_fm_en && a_row == 0 && a_col == 0, "restart_row0", 7, {a_fm_en, a_row, a_col}, 32'h10);
    step();
    i_abort = 1'b1; step(); i_abort = 1'b0;

    // abort during weight load lets the in-flight beat through
    i_start = 1'b1; step(); i_start = 1'b0;
    step(); step();
    i_abort = 1'b1; step(); i_abort = 1'b0;
    @(negedge clk_sys);
    chk(!a_rd_en && a_wvld && !a_busy, "abort_wload", 4, {a_rd_en, a_wvld, a_busy}, 32'b010);
    step(); @(negedge clk_sys);
    chk(!a_wvld && !b_wvld, "abort_wload_end", 5, {a_wvld, b_wvld}, 0);

    // abort beats a same-cycle start
    step();
    i_start = 1'b1; i_abort = 1'b1; step(); i_start = 1'b0; i_abort = 1'b0;
    @(negedge clk_sys);
    chk(!a_busy && !a_vsync && !b_busy, "abort_over_start", 1, {a_busy, a_vsync, b_busy}, 0);

    // reset mid-WLOAD clears outputs at once, then addr 0 leads the next frame
    step();
    i_start = 1'b1; step(); i_start = 1'b0;
    step(); step();
    @(negedge clk_sys);
    chk(a_rd_en && b_rd_en, "pre_reset_wload", 3, {a_rd_en, b_rd_en}, 3);
    #1 i_rst = 1'b1;
    #1;
    chk(all_zero(), "reset_async", 3, 32'(rd_a()), 0);
    @(posedge clk_sys);
    @(negedge clk_sys);
    chk(all_zero(), "reset_hold", 0, 32'(rd_a()), 0);
    i_rst = 1'b0;
    step();
    i_start = 1'b1; step(); i_start = 1'b0;
    @(negedge clk_sys);
    chk(a_vsync && b_vsync && a_busy, "post_reset_vsync", 1, {a_vsync, b_vsync, a_busy}, 7);
    step(); step(); @(negedge clk_sys);
    chk(a_rd_en && a_addr == 0 && b_rd_en && b_addr == 0, "post_reset_addr0", 3, a_addr, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/bconv_seq.md
BCONV_SEQ -- requirements
Module: bconv_seq

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- CHANNEL, 256, input channels per pixel
- SIZE, 56, row length in pixels and rows per frame
- BATCH, 2, output channels per weight group
- PACK, 8, channels per weight beat
- WIDTH_W, 18, weight bits per channel (2-bit x 3x3)
- GAP, 0, idle cycles after each group stream
- PB, CHANNEL/PACK, weight beats per group
- GROUPS, CHANNEL/BATCH, groups per row
- WA, clog2(GROUPS*PB), weight address width
- PA, clog2(SIZE), pixel/row index width

REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- i_sclk, in, 1, sole clock, rising edge
- i_rst, in, 1, asynchronous active-high reset
- i_start, in, 1, frame start pulse
- i_abort, in, 1, synchronous abort
- i_ready, in, 1, downstream can accept next group
- o_wt_rd_en, out, 1, weight memory read enable
- o_wt_rd_addr, out, WA, weight read address
- i_wt_rd_data, in, WIDTH_W*PACK, weight data, 1-cycle latency
- o_weight_vld, out, 1, weight beat valid to conv
- o_weight, out, WIDTH_W*PACK, weight beat to conv
- o_fm_rd_en, out, 1, feature-map read enable
- o_fm_col, out, PA, pixel column
- o_fm_row, out, PA, pixel row
- o_vsync, out, 1, frame-start pulse
- o_hsync, out, 1, row-start pulse
- o_reuse, out, 1, group weight-commit pulse
- o_valid, out, 1, feature pixel valid, aligned with fm data
- o_busy, out, 1, frame in progress
- o_done, out, 1, frame-complete pulse

Function
REQ-003 FSM states SHALL be IDLE, VS, HS, WCHK, WLOAD, WLAT, REUSE, STREAM, GAP, DONE.
REQ-004 IDLE: i_start=1 -> VS; otherwise stay; i_start outside IDLE SHALL be ignored.
REQ-005 VS SHALL last 1 cycle with o_vsync=1, clearing row, group and beat counters -> HS.
REQ-006 HS SHALL last 1 cycle with o_hsync=1 -> WCHK.
REQ-007 WCHK: i_ready=1 -> WLOAD in the same cycle (zero-cycle check); i_ready=0 -> hold with all strobes low.
REQ-008 WLOAD SHALL last PB cycles with o_wt_rd_en=1 and o_wt_rd_addr=group*PB+beat, beat 0..PB-1 -> WLAT.
REQ-009 o_weight_vld and o_weight SHALL equal o_wt_rd_en and i_wt_rd_data delayed by one register stage.
REQ-010 WLAT SHALL last 1 cycle so the final weight beat lands before the commit -> REUSE.
REQ-011 REUSE SHALL last 1 cycle with o_reuse=1 -> STREAM.
REQ-012 STREAM SHALL last SIZE cycles with o_fm_rd_en=1, o_fm_col=0..SIZE-1 and o_fm_row=current row; o_valid SHALL equal o_fm_rd_en delayed 1 cycle.
REQ-013 GAP SHALL last GAP cycles and is skipped when GAP=0.
REQ-014 After GAP: group<GROUPS-1 -> group+1, WCHK; else row<SIZE-1 -> row+1, group=0, HS; else DONE.
REQ-015 DONE SHALL last 1 cycle with o_done=1 -> IDLE.
REQ-016 o_busy SHALL be 1 in every state except IDLE.
REQ-017 i_abort=1 in any non-IDLE state SHALL force IDLE at the next edge; o_done SHALL not pulse; delayed o_weight_vld/o_valid SHALL still complete their in-flight beat; i_abort overrides a same-cycle i_start.
REQ-018 Counters SHALL wrap only via explicit clears; no arithmetic overflow is permitted.
REQ-019 Cycles per group SHALL be PB+2+SIZE+GAP when i_ready is held high.

Reset
REQ-020 i_rst=1 SHALL asynchronously force IDLE, clear all counters and delay stages, and drive every output to 0 (o_weight=0), including mid-frame.
REQ-021 After i_rst deasserts, the first i_start SHALL be honoured from the next edge.

Verification (CHANNEL=16, PACK=8, BATCH=2, SIZE=4, GAP=2; PB=2, GROUPS=8)
REQ-022 i_start at cycle 0 with i_ready=1 -> o_vsync at cycle 1, o_hsync at cycle 2, o_done at cycle 326, and o_busy high for cycles 1..326 inclusive.
REQ-023 Group 3 of row 1 -> o_wt_rd_addr 6,7; o_weight_vld lags each address by 1; o_reuse 2 cycles after addr 7; o_valid 4 cycles with o_fm_row=1.
REQ-024 i_ready=0 for 5 cycles during WCHK of group 2 -> no strobes during the stall; frame completes 5 cycles later (cycle 331).
REQ-025 i_abort mid-STREAM -> o_busy=0 next cycle; one trailing o_valid; no o_done; a new i_start then restarts from row 0, group 0.
REQ-026 i_rst pulsed mid-WLOAD -> all outputs 0 immediately; i_start afterwards yields addr 0 first.
REQ-027 GAP=0 rerun -> 8 cycles per group, o_done at cycle 262.
